// File: rtl/fp_pkg.sv
// Shared constants and types for the normalizer path.
// Bit positions refer to the 28-bit extended mantissa layout.
package fp_pkg;
    localparam int EXP_W      = 8;
    localparam int MANT_W     = 28;
    localparam int HIDDEN_BIT = 26;
    localparam int CARRY_BIT  = 27;
    localparam int ROUND_LSB  = 4;

    localparam logic [EXP_W-1:0] EXP_MAX        = 8'd255;
    localparam logic [EXP_W-1:0] EXP_MAX_FINITE = 8'd254;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;
endpackage

// File: rtl/normalize_seq_if.sv
// Operand/result handshake bundle between the add/sub datapath, the
// normalizer and the round stage.
interface normalize_seq_if;
    import fp_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mantis;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  exp_out;
    logic [MANT_W-1:0] mantis_out;
    logic              ovf;
    logic              unf;

    modport master (
        output in_valid, exp, mantis, out_ready,
        input  in_ready, out_valid, exp_out, mantis_out, ovf, unf
    );

    modport slave (
        input  in_valid, exp, mantis, out_ready,
        output in_ready, out_valid, exp_out, mantis_out, ovf, unf
    );
endinterface

// File: rtl/normalize_seq_step.sv
// One combinational normalization step: picks the highest-priority action
// for the current exponent/mantissa and reports whether the result is final.
module norm_step
    import fp_pkg::*;
(
    input  logic [EXP_W-1:0]  e_i,
    input  logic [MANT_W-1:0] m_i,
    output logic [EXP_W-1:0]  e_o,
    output logic [MANT_W-1:0] m_o,
    output logic              ovf_o,
    output logic              unf_o,
    output logic              done_o
);
    always_comb begin
        e_o    = e_i;
        m_o    = m_i;
        ovf_o  = 1'b0;
        unf_o  = 1'b0;
        done_o = 1'b1;
        if (e_i == EXP_MAX) begin
            // Infinity/NaN exponent passes through; carry cleared so it never leaks out.
            ovf_o          = 1'b1;
            m_o[CARRY_BIT] = 1'b0;
        end else if (m_i == '0) begin
            e_o   = '0;
            unf_o = 1'b1;
        end else if (m_i[CARRY_BIT]) begin
            if (e_i == EXP_MAX_FINITE) begin
                e_o   = EXP_MAX;
                m_o   = '0;
                ovf_o = 1'b1;
            end else begin
                m_o = {1'b0, m_i[CARRY_BIT:2], m_i[1] | m_i[0]};
                e_o = e_i + 8'd1;
            end
        end else if (e_i == '0) begin
            if (m_i[HIDDEN_BIT]) begin
                e_o = 8'd1;
            end else begin
                unf_o = 1'b1;
            end
        end else if (m_i[HIDDEN_BIT]) begin
            done_o = 1'b1;
        end else if (e_i == 8'd1) begin
            e_o   = '0;
            unf_o = 1'b1;
        end else begin
            m_o    = m_i << 1;
            e_o    = e_i - 8'd1;
            done_o = 1'b0;
        end
    end
endmodule

// File: rtl/normalize_seq.sv
// Sequential normalizer: accepts one operand, left-shifts one bit per cycle
// (or right-shifts once on carry) and holds the result until the round stage takes it.
module normalize_seq
    import fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    normalize_seq_if.slave  bus
);
    state_t            state_q;
    logic [EXP_W-1:0]  e_q;
    logic [MANT_W-1:0] m_q;
    logic [EXP_W-1:0]  exp_out_q;
    logic [MANT_W-1:0] mantis_out_q;
    logic              ovf_q;
    logic              unf_q;
    logic              out_valid_q;

    logic [EXP_W-1:0]  e_d;
    logic [MANT_W-1:0] m_d;
    logic              ovf_d;
    logic              unf_d;
    logic              done_d;

    norm_step u_step (
        .e_i    (e_q),
        .m_i    (m_q),
        .e_o    (e_d),
        .m_o    (m_d),
        .ovf_o  (ovf_d),
        .unf_o  (unf_d),
        .done_o (done_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            e_q          <= '0;
            m_q          <= '0;
            exp_out_q    <= '0;
            mantis_out_q <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        e_q     <= bus.exp;
                        m_q     <= bus.mantis;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    e_q <= e_d;
                    m_q <= m_d;
                    if (done_d) begin
                        exp_out_q    <= e_d;
                        mantis_out_q <= m_d;
                        ovf_q        <= ovf_d;
                        unf_q        <= unf_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst so upstream never sees a ready while reset is held.
    assign bus.in_ready   = (state_q == IDLE) && !rst;
    assign bus.out_valid  = out_valid_q;
    assign bus.exp_out    = exp_out_q;
    assign bus.mantis_out = mantis_out_q;
    assign bus.ovf        = ovf_q;
    assign bus.unf        = unf_q;
endmodule

// File: tb/tb_normalize_seq.sv
// Bench for normalize_seq: directed vector table, stall/reset sequences and
// randomized operands checked against an arithmetic reference model.
module tb_normalize_seq;
    import fp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    normalize_seq_if bus();

    normalize_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  e;
        logic [27:0] m;
        logic [7:0]  eo;
        logic [27:0] mo;
        logic        ov;
        logic        un;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: closed-form result from leading-one position, no step simulation.
    function automatic void model(input logic [7:0] e, input logic [27:0] m,
                                  output logic [7:0] eo, output logic [27:0] mo,
                                  output logic ov, output logic un, output int lat);
        int p;
        int s;
        int ei;
        ov  = 1'b0;
        un  = 1'b0;
        lat = 2;
        eo  = e;
        mo  = m;
        ei  = int'(e);
        if (e == 8'd255) begin
            ov = 1'b1;
            mo = m & 28'h7FFFFFF;
        end else if (m == 28'd0) begin
            eo = 8'd0;
            un = 1'b1;
        end else if (m[27]) begin
            if (e == 8'd254) begin
                eo = 8'd255;
                mo = 28'd0;
                ov = 1'b1;
            end else begin
                eo = 8'(ei + 1);
                mo = (m >> 1) | {27'd0, m[0]};
            end
        end else if (e == 8'd0) begin
            eo = m[26] ? 8'd1 : 8'd0;
            un = !m[26];
        end else begin
            p = 0;
            for (int i = 0; i <= 26; i++) if (m[i]) p = i;
            s = 26 - p;
            if (s <= ei - 1) begin
                eo  = 8'(ei - s);
                mo  = m << s;
                lat = s + 2;
            end else begin
                eo  = 8'd0;
                mo  = m << (ei - 1);
                un  = 1'b1;
                lat = ei + 1;
            end
        end
    endfunction

    task automatic do_op(input logic [7:0] e, input logic [27:0] m,
                         output logic [7:0] eo, output logic [27:0] mo,
                         output logic ov, output logic un, output int lat);
        int cnt;
        cnt = 0;
        bus.in_valid = 1'b1;
        bus.exp      = e;
        bus.mantis   = m;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        lat = bus.out_valid ? cnt + 1 : -1;
        eo  = bus.exp_out;
        mo  = bus.mantis_out;
        ov  = bus.ovf;
        un  = bus.unf;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  eo, e_ref, e_r;
        logic [27:0] mo, m_ref, m_r, one, rnd;
        logic        ov, un, ov_ref, un_ref;
        int          lat, lat_ref, p, stale;

        vecs[0]  = '{8'd127, 28'h4000000, 8'd127, 28'h4000000, 1'b0, 1'b0, 2};
        vecs[1]  = '{8'd100, 28'h8000003, 8'd101, 28'h4000001, 1'b0, 1'b0, 2};
        vecs[2]  = '{8'd127, 28'h0000010, 8'd105, 28'h4000000, 1'b0, 1'b0, 24};
        vecs[3]  = '{8'd3,   28'h0100000, 8'd0,   28'h0400000, 1'b0, 1'b1, 4};
        vecs[4]  = '{8'd254, 28'h8000000, 8'd255, 28'h0000000, 1'b1, 1'b0, 2};
        vecs[5]  = '{8'd77,  28'h0000000, 8'd0,   28'h0000000, 1'b0, 1'b1, 2};
        vecs[6]  = '{8'd255, 28'h1234567, 8'd255, 28'h1234567, 1'b1, 1'b0, 2};
        vecs[7]  = '{8'd0,   28'h4000000, 8'd1,   28'h4000000, 1'b0, 1'b0, 2};
        vecs[8]  = '{8'd0,   28'h0000123, 8'd0,   28'h0000123, 1'b0, 1'b1, 2};
        vecs[9]  = '{8'd1,   28'h0000001, 8'd0,   28'h0000001, 1'b0, 1'b1, 2};
        vecs[10] = '{8'd127, 28'h0000001, 8'd101, 28'h4000000, 1'b0, 1'b0, 28};
        vecs[11] = '{8'd26,  28'h0000001, 8'd0,   28'h2000000, 1'b0, 1'b1, 27};

        bus.in_valid  = 1'b0;
        bus.exp       = '0;
        bus.mantis    = '0;
        bus.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_exp_out", bus.exp_out, 0);
        check("rst_mantis_out", bus.mantis_out, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_unf", bus.unf, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].e, vecs[i].m, eo, mo, ov, un, lat);
            $display("vec %0d exp=%0d mantis=%h -> exp_out=%0d mantis_out=%h ovf=%0b unf=%0b lat=%0d",
                     i, vecs[i].e, vecs[i].m, eo, mo, ov, un, lat);
            check($sformatf("vec%0d_exp_out", i), eo, vecs[i].eo);
            check($sformatf("vec%0d_mantis_out", i), mo, vecs[i].mo);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].ov);
            check($sformatf("vec%0d_unf", i), un, vecs[i].un);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            @(posedge clk); #1;
            check($sformatf("vec%0d_out_valid_drop", i), bus.out_valid, 0);
            check($sformatf("vec%0d_in_ready_back", i), bus.in_ready, 1);
        end

        // Stall in DONE for 5 cycles while a competing operand is offered
        bus.out_ready = 1'b0;
        do_op(8'd100, 28'h8000003, eo, mo, ov, un, lat);
        bus.in_valid = 1'b1;
        bus.exp      = 8'd5;
        bus.mantis   = 28'h0000100;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_exp_out", bus.exp_out, 8'd101);
            check("stall_mantis_out", bus.mantis_out, 28'h4000001);
            check("stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        $display("stall release -> out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);
        check("stall_release_out_valid", bus.out_valid, 0);
        check("stall_release_in_ready", bus.in_ready, 1);

        // Reset in the middle of a long shift sequence
        bus.in_valid = 1'b1;
        bus.exp      = 8'd127;
        bus.mantis   = 28'h0000010;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midshift_in_ready", bus.in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        #1;
        check("midrst_idle", bus.in_ready, 1);
        check("midrst_exp_out", bus.exp_out, 0);
        check("midrst_mantis_out", bus.mantis_out, 0);
        stale = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (bus.out_valid) stale++;
        end
        $display("reset mid-shift -> stale out_valid cycles=%0d", stale);
        check("midrst_stale_result", stale, 0);

        // Randomized operands against the reference model
        one = 28'd1;
        for (int n = 0; n < 150; n++) begin
            p   = $urandom_range(0, 28);
            rnd = 28'($urandom);
            if (p == 28) m_r = 28'd0;
            else         m_r = (one << p) | (rnd & ((one << p) - one));
            if ($urandom_range(0, 3) == 0) e_r = 8'($urandom_range(0, 30));
            else                           e_r = 8'($urandom_range(0, 254));
            model(e_r, m_r, e_ref, m_ref, ov_ref, un_ref, lat_ref);
            do_op(e_r, m_r, eo, mo, ov, un, lat);
            $display("rnd %0d exp=%0d mantis=%h -> exp_out=%0d mantis_out=%h ovf=%0b unf=%0b lat=%0d (ref %0d %h %0b %0b %0d)",
                     n, e_r, m_r, eo, mo, ov, un, lat, e_ref, m_ref, ov_ref, un_ref, lat_ref);
            check("rnd_exp_out", eo, e_ref);
            check("rnd_mantis_out", mo, m_ref);
            check("rnd_ovf", ov, ov_ref);
            check("rnd_unf", un, un_ref);
            check("rnd_latency", lat, lat_ref);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/normalize_seq.md
Name: normalize_seq

Overview:
- Sequential normalizer that sits directly upstream of the round stage in the standardizer path.
- Accepts the raw 28-bit extended mantissa and 8-bit exponent produced by the add/sub datapath.
- Shifts the mantissa until the hidden bit sits at bit 26, using at most one bit per cycle, and adjusts the exponent to match.
- Delivers a mantissa/exponent pair ready for rounding, with valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent width; the only supported value is 8.
- MANT_W, 28, extended mantissa width. Layout: bit 27 = carry-out, bit 26 = hidden bit, bits 25:4 = fraction, bits 3:0 = round bits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- exp  in  8  input biased exponent.
- mantis  in  28  input extended mantissa.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream (round) accepts the result.
- exp_out  out  8  normalized exponent.
- mantis_out  out  28  normalized mantissa; bit 27 is always 0 when out_valid.
- ovf  out  1  exponent overflowed; result forced to infinity.
- unf  out  1  result is denormal or zero after normalization.

Behaviour:
- Reset values: in_ready=0 during reset and 1 in the first cycle after; out_valid=0; exp_out=0; mantis_out=0; ovf=0; unf=0; FSM=IDLE.
- States and transitions:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) registers exp/mantis into working registers e/m and moves to SHIFT.
  - SHIFT: in_ready=0. Performs one action per cycle, in priority order:
    1. m==0 → e=0, unf=1, go to DONE.
    2. m[27]=1 → e==254: e=255, m=0, ovf=1, go to DONE. Otherwise: m = {1'b0, m[27:2], m[1]|m[0]} (sticky preserved), e=e+1, go to DONE.
    3. e==0 → input already denormal. If m[26]=1, set e=1. Otherwise set unf=1. Go to DONE.
    4. m[26]=1 → go to DONE.
    5. e==1 → denormal: e=0, unf=1, go to DONE.
    6. Otherwise: m = m<<1 (zero fill), e=e-1, stay in SHIFT.
  - DONE: out_valid=1; outputs driven from e/m/flags. On out_ready=1: out_valid drops next cycle and the FSM returns to IDLE. Outputs stay stable while out_ready=0.
- Latency:
  - Handshake to out_valid = 1 + k cycles, where k = number of SHIFT cycles.
  - Already normalized or carry case: k=1.
  - Worst case: 26 left shifts plus the terminating check, so k=27.
- Throughput: one operand in flight at a time. in_ready=0 in SHIFT and DONE; no overlap of a new accept with an output transfer.
- Arithmetic:
  - Exponent arithmetic is unsigned 8-bit and never wraps, because rules 2 and 5 bound it.
  - Input exp=255 is passed through unchanged with ovf=1; this check is made before rule 1.
- Flags are cleared on every accept.
- Reset mid-operation (SHIFT or DONE) discards the operand. The next cycle is IDLE with all outputs at reset values.
- in_valid asserted while in_ready=0 is ignored; upstream must hold its data until accepted.

Decomposition:
- Shared package fp_pkg holds:
  - EXP_W, MANT_W
  - bit-position constants HIDDEN_BIT=26, CARRY_BIT=27, ROUND_LSB=4
  - EXP_MAX=8'd255, EXP_MAX_FINITE=8'd254
  - state enum IDLE/SHIFT/DONE
- One natural sub-module: norm_step, a combinational single-step decision and shift covering rules 1–6. It returns next e, next m, flags and a done bit, so it can be unit-tested standalone.

Test Plan:
- exp=8'd127, mantis=28'h4000000 (hidden bit set) → after 2 cycles out_valid; exp_out=127, mantis_out=28'h4000000, ovf=0, unf=0.
- exp=8'd100, mantis=28'h8000003 (carry set) → exp_out=101, mantis_out=28'h4000001 (sticky kept), 2-cycle latency.
- exp=8'd127, mantis=28'h0000010 → 22 left shifts; exp_out=105, mantis_out=28'h4000000, latency 24 cycles.
- exp=8'd3, mantis=28'h0100000 → shifts stop at e=1; exp_out=0, mantis_out=28'h0400000, unf=1.
- exp=8'd254, mantis=28'h8000000 → exp_out=255, mantis_out=0, ovf=1. Separately, mantis=0 with any exp → exp_out=0, unf=1.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable and in_ready=0. Then assert rst mid-SHIFT → next cycle out_valid=0, state IDLE, no stale result emitted.
